mp_addsub_seq: RTL and testbench

- Multi-cycle, multi-precision add/subtract sequencer built around one 16-bit carry-lookahead adder (cla_16b).
- Processes a WORDS*16-bit operation as WORDS consecutive 16-bit slices, least-significant slice first, and registers the carry between slices.
- Uses valid/ready handshakes on both sides. Serves as the wide-arithmetic helper beside the ALU, trading latency for area.

---
 rtl/mp_addsub_pkg.sv | 22 ++
 rtl/cla_16b.sv | 58 +++++
 rtl/mp_addsub_seq.sv | 133 +++++++++++++
 tb/tb_mp_addsub_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mp_addsub_pkg.sv
// Shared types and constants for the multi-precision add/sub sequencer.
package mp_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 16;

  // Bits needed to hold values 0..v-1; never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cla_16b.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a group-level lookahead unit.
// Purely combinational; no flow control.
module cla_16b (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;
  logic [15:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    w_gg = '0;
    w_gp = '0;
    for (int j = 0; j < 4; j++) begin
      w_gp[j] = &w_p[4*j +: 4];
      w_gg[j] = w_g[4*j+3]
              | (w_p[4*j+3] & w_g[4*j+2])
              | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
              | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
    end
  end

  assign w_gc[0] = i_cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

  // Bit carries inside each group start from that group's lookahead carry.
  always_comb begin
    w_c = '0;
    for (int j = 0; j < 4; j++) begin
      w_c[4*j]   = w_gc[j];
      w_c[4*j+1] = w_g[4*j]   | (w_p[4*j]   & w_gc[j]);
      w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j]) | (w_p[4*j+1] & w_p[4*j] & w_gc[j]);
      w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                 | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                 | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_gc[j]);
    end
  end

  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_gc[4];

endmodule

// File: rtl/mp_addsub_seq.sv
// WORDS*16-bit add/sub through one 16-bit CLA, one slice per cycle, least-significant first.
// Latency: accept edge plus WORDS RUN edges; out_valid the cycle after. One op per WORDS+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. MPADD_FLAGS_EN adds zero/ovf.
module mp_addsub_seq
  import mp_addsub_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     sub,
  input  logic [SLICE_W*WORDS-1:0] a,
  input  logic [SLICE_W*WORDS-1:0] b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] result,
  output logic                     c_out
`ifdef MPADD_FLAGS_EN
  ,
  output logic                     zero,
  output logic                     ovf
`endif
);

  localparam int W  = SLICE_W * WORDS;
  localparam int IW = clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t              r_state;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic [W-1:0]        r_result;
  logic                r_carry;
  logic [IW-1:0]       r_idx;
  logic                r_c_out;

  logic [SLICE_W-1:0]  w_a_sl;
  logic [SLICE_W-1:0]  w_b_sl;
  logic [SLICE_W-1:0]  w_sum;
  logic                w_cout;
  logic                w_last;

  assign w_a_sl = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_b_sl = r_b[r_idx*SLICE_W +: SLICE_W];
  assign w_last = (r_idx == LAST_IDX);

  cla_16b u_cla (
    .i_a    (w_a_sl),
    .i_b    (w_b_sl),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign c_out     = r_c_out;

  // Subtraction is A + ~B + 1: the inverted operand is stored and the +1 rides in as initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_c_out  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_result[r_idx*SLICE_W +: SLICE_W] <= w_sum;
          r_carry <= w_cout;
          if (w_last) begin
            r_c_out <= w_cout;
            r_idx   <= '0;
            r_state <= DONE;
          end else begin
            r_idx   <= r_idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MPADD_FLAGS_EN
  logic r_zacc;
  logic r_zero;
  logic r_ovf;
  logic w_top_cin;

  // Carry into the top bit recovered from the top slice's MSB inputs and sum.
  assign w_top_cin = w_a_sl[SLICE_W-1] ^ w_b_sl[SLICE_W-1] ^ w_sum[SLICE_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zacc <= 1'b0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_zacc <= 1'b1;
      end else if (r_state == RUN) begin
        r_zacc <= r_zacc & (w_sum == '0);
        if (w_last) begin
          r_zero <= r_zacc & (w_sum == '0);
          r_ovf  <= w_top_cin ^ w_cout;
        end
      end
    end
  end

  assign zero = r_zero;
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Directed bench for mp_addsub_seq (WORDS=4); flag checks compile in when MPADD_FLAGS_EN is defined.
module tb_mp_addsub_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         c_out;
`ifdef MPADD_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mp_addsub_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_out     (c_out)
`ifdef MPADD_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return #1 after the edge that accepts it; operands are scrambled afterwards.
  task automatic send(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    in_valid = 1'b1;
    sub = s;
    a = x;
    b = y;
    step();
    in_valid = 1'b0;
    sub = ~s;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  // Edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;

    // Reset state
    #3;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_result", result, '0);
    chk("rst_c_out", W'(c_out), W'(0));
`ifdef MPADD_FLAGS_EN
    chk("rst_zero", W'(zero), W'(0));
    chk("rst_ovf", W'(ovf), W'(0));
`endif
    #14 rst_n = 1'b1;
    step();

    // 1: all-ones + 1 wraps to zero with carry out; out_valid in the 5th cycle after the accept cycle
    send(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    wait_done(lat);
    chk("t1_latency", W'(lat), W'(WORDS));
    chk("t1_out_valid", W'(out_valid), W'(1));
    chk("t1_result", result, 64'h0);
    chk("t1_c_out", W'(c_out), W'(1));
`ifdef MPADD_FLAGS_EN
    chk("t1_zero", W'(zero), W'(1));
    chk("t1_ovf", W'(ovf), W'(0));
`endif
    take();
    chk("t1_after_take_out_valid", W'(out_valid), W'(0));
    chk("t1_after_take_in_ready", W'(in_ready), W'(1));

    // 2: 0 - 1 borrows all the way through
    send(1'b1, 64'h0, 64'h1);
    wait_done(lat);
    chk("t2_latency", W'(lat), W'(WORDS));
    chk("t2_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2_c_out", W'(c_out), W'(0));
`ifdef MPADD_FLAGS_EN
    chk("t2_zero", W'(zero), W'(0));
    chk("t2_ovf", W'(ovf), W'(0));
`endif
    take();

    // 3: max positive + 1 overflows signed range
    send(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    wait_done(lat);
    chk("t3_result", result, 64'h8000_0000_0000_0000);
    chk("t3_c_out", W'(c_out), W'(0));
`ifdef MPADD_FLAGS_EN
    chk("t3_ovf", W'(ovf), W'(1));
    chk("t3_zero", W'(zero), W'(0));
`endif
    take();

    // 3b: subtraction with no borrow, carries crossing slice boundaries
    send(1'b1, 64'h0001_0000_0000_0000, 64'h1);
    wait_done(lat);
    chk("t3b_result", result, 64'h0000_FFFF_FFFF_FFFF);
    chk("t3b_c_out", W'(c_out), W'(1));
    take();

    // 4: backpressure holds result; in_ready stays low until handshake
    send(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111);
    wait_done(lat);
    chk("t4_latency", W'(lat), W'(WORDS));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4_hold_result_%0d", i), result, 64'h2345_6789_ABCD_F001);
      chk($sformatf("t4_hold_in_ready_%0d", i), W'(in_ready), W'(0));
      chk($sformatf("t4_hold_out_valid_%0d", i), W'(out_valid), W'(1));
      step();
    end
    chk("t4_c_out", W'(c_out), W'(0));
    take();
    chk("t4_in_ready_after", W'(in_ready), W'(1));

    // 5: in_valid held high with new operands during RUN/DONE is ignored
    send(1'b0, 64'h5, 64'h6);
    in_valid = 1'b1;
    sub = 1'b0;
    a = 64'h100;
    b = 64'h200;
    chk("t5_run_in_ready", W'(in_ready), W'(0));
    wait_done(lat);
    chk("t5_latency", W'(lat), W'(WORDS));
    chk("t5_result_first", result, 64'hB);
    step();
    chk("t5_done_hold_result", result, 64'hB);
    chk("t5_done_in_ready", W'(in_ready), W'(0));
    // handshake and in_valid together: not accepted this edge
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t5_idle_in_ready", W'(in_ready), W'(1));
    chk("t5_idle_out_valid", W'(out_valid), W'(0));
    step();
    in_valid = 1'b0;
    chk("t5_second_accepted", W'(in_ready), W'(0));
    wait_done(lat);
    chk("t5_second_latency", W'(lat), W'(WORDS));
    chk("t5_second_result", result, 64'h300);
    take();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("t5_no_extra_result", W'(seen), W'(0));

    // 6: asynchronous reset after two RUN cycles aborts the request
    send(1'b0, 64'hDEAD_BEEF_0123_4567, 64'h1111_2222_3333_4444);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", W'(out_valid), W'(0));
    chk("t6_rst_in_ready", W'(in_ready), W'(1));
    chk("t6_rst_result", result, 64'h0);
    chk("t6_rst_c_out", W'(c_out), W'(0));
    step();
    #3 rst_n = 1'b1;
    step();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("t6_no_ghost_valid", W'(seen), W'(0));
    send(1'b0, 64'h5, 64'h3);
    wait_done(lat);
    chk("t6_latency", W'(lat), W'(WORDS));
    chk("t6_result", result, 64'h8);
    chk("t6_c_out", W'(c_out), W'(0));
`ifdef MPADD_FLAGS_EN
    chk("t6_zero", W'(zero), W'(0));
`endif
    take();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
